// File: rtl/serv_dbus_bridge_pkg.sv
// Shared types and width helpers for the SERV serial data-bus bridge.
// The state encoding here is also what the debug state output carries.
package serv_dbus_bridge_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WCOLLECT = 3'd1,
    ST_BUS      = 3'd2,
    ST_RSHIFT   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Number of serial beats that make up one bus word.
  function automatic int unsigned beats_of(input int unsigned w);
    return DATA_W / w;
  endfunction

  // Width of a counter that can index every beat of a word.
  function automatic int unsigned cnt_w_of(input int unsigned w);
    return (DATA_W / w <= 2) ? 1 : $clog2(DATA_W / w);
  endfunction

endpackage

// File: rtl/serv_dbus_bridge_if.sv
// Wishbone classic data-bus bundle between the bridge (master) and the bus fabric (slave).
// stb is not carried; the integrator ties it to cyc.
interface serv_dbus_bridge_if;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  // Handshake: a transfer completes in the cycle where o_wb_cyc and i_wb_ack are both high;
  // address, data, select and we are held stable from cyc rising until the cycle after ack.
  modport master (
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  i_wb_rdt, i_wb_ack
  );

  modport slave (
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output i_wb_rdt, i_wb_ack
  );

endinterface

// File: rtl/serv_dbus_bridge_shreg.sv
// 32-bit data register shared by the store-collect and load-shift paths:
// parallel load, W-bit serial in at the MSB end, W-bit serial out at the LSB end.
module serv_dbus_shreg
  import serv_dbus_bridge_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_ld_dat,
  input  logic              i_shift,
  input  logic [W-1:0]      i_sin,
  output logic [DATA_W-1:0] o_q,
  output logic [W-1:0]      o_sout
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_ld_dat;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[DATA_W-1:W]};
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[W-1:0];

endmodule

// File: rtl/serv_dbus_bridge.sv
// Bridge between SERV's W-bit serial memory datapath and a 32-bit Wishbone classic bus,
// with a timeout guard so a missing ack completes the access with an error instead of hanging.
module serv_dbus_bridge
  import serv_dbus_bridge_pkg::*;
#(
  parameter int W       = 8,
  parameter int B       = W - 1,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [3:0]  i_sel,
  input  logic [B:0]  i_wdat,
  input  logic        i_wvalid,
  output logic [B:0]  o_rdat,
  output logic        o_rvalid,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  output state_t      o_dbg_state,
  serv_dbus_bridge_if.master wb
);

  localparam int unsigned  BEATS     = beats_of(W);
  localparam int unsigned  CW        = cnt_w_of(W);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [7:0]   TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0]  ADR_MASK  = 32'hFFFF_FFFC;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_adr;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_tcnt;
  logic             r_err;

  logic             w_tmo;
  logic             w_last;
  logic             w_beat;
  logic             w_load;
  logic             w_clr;
  logic             w_shift;
  logic [B:0]       w_sin;
  logic [31:0]      w_q;
  logic [B:0]       w_sout;

  // Timeout fires on the TIMEOUT-th cycle of cyc, so cyc is high for exactly TIMEOUT cycles.
  assign w_tmo  = (r_tcnt == TMO_LAST);
  assign w_last = (r_cnt == LAST_BEAT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_beat  = 1'b0;
    w_load  = 1'b0;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_sin   = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_next = i_we ? ST_WCOLLECT : ST_BUS;
        end
      end
      ST_WCOLLECT: begin
        if (i_wvalid) begin
          w_beat  = 1'b1;
          w_shift = 1'b1;
          w_sin   = i_wdat;
          if (w_last) begin
            w_next = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Ack takes priority over a coincident timeout.
        if (wb.i_wb_ack) begin
          w_next = r_we ? ST_DONE : ST_RSHIFT;
          w_load = !r_we;
        end else if (w_tmo) begin
          w_next = r_we ? ST_DONE : ST_RSHIFT;
          w_clr  = !r_we;
        end
      end
      ST_RSHIFT: begin
        w_beat  = 1'b1;
        w_shift = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adr  <= '0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_req) begin
        r_adr <= i_adr & ADR_MASK;
        r_we  <= i_we;
        r_sel <= i_sel;
      end
      if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      r_tcnt <= (r_state == ST_BUS) ? r_tcnt + 8'd1 : 8'd0;
      if (r_state == ST_BUS && !wb.i_wb_ack && w_tmo) begin
        r_err <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  serv_dbus_shreg #(
    .W (W)
  ) u_shreg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_load   (w_load),
    .i_ld_dat (wb.i_wb_rdt),
    .i_shift  (w_shift),
    .i_sin    (w_sin),
    .o_q      (w_q),
    .o_sout   (w_sout)
  );

  // Bus and core outputs decode straight from registers so reset clears them without a clock.
  assign wb.o_wb_cyc = (r_state == ST_BUS);
  assign wb.o_wb_adr = r_adr;
  assign wb.o_wb_dat = w_q;
  assign wb.o_wb_sel = r_sel;
  assign wb.o_wb_we  = r_we;

  assign o_rvalid    = (r_state == ST_RSHIFT);
  assign o_rdat      = w_sout;
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = (r_state == ST_DONE) && r_err;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serv_dbus_bridge.sv
// Bench for serv_dbus_bridge: a W=8 and a W=1 instance, both with TIMEOUT=16,
// checked against expected-beat and expected-write queues.
module tb_serv_dbus_bridge;
  import serv_dbus_bridge_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp8_q[$];
  logic [0:0]  exp1_q[$];
  logic [35:0] expwr_q[$];

  // W=8 instance
  logic        req8 = 0, we8 = 0, wvalid8 = 0;
  logic [31:0] adr8 = '0;
  logic [3:0]  sel8 = '0;
  logic [7:0]  wdat8 = '0;
  logic [7:0]  rdat8;
  logic        rv8, done8, err8, busy8;
  state_t      st8;
  serv_dbus_bridge_if wb8();

  serv_dbus_bridge #(.W(8), .TIMEOUT(TMO)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req8), .i_we(we8), .i_adr(adr8),
    .i_sel(sel8), .i_wdat(wdat8), .i_wvalid(wvalid8), .o_rdat(rdat8),
    .o_rvalid(rv8), .o_done(done8), .o_err(err8), .o_busy(busy8),
    .o_dbg_state(st8), .wb(wb8)
  );

  // W=1 instance
  logic        req1 = 0, we1 = 0, wvalid1 = 0;
  logic [31:0] adr1 = '0;
  logic [3:0]  sel1 = '0;
  logic [0:0]  wdat1 = '0;
  logic [0:0]  rdat1;
  logic        rv1, done1, err1, busy1;
  state_t      st1;
  serv_dbus_bridge_if wb1();

  serv_dbus_bridge #(.W(1), .TIMEOUT(TMO)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_we(we1), .i_adr(adr1),
    .i_sel(sel1), .i_wdat(wdat1), .i_wvalid(wvalid1), .o_rdat(rdat1),
    .o_rvalid(rv1), .o_done(done1), .o_err(err1), .o_busy(busy1),
    .o_dbg_state(st1), .wb(wb1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: serial read beats and completed bus writes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv8) begin
        chk("rv8_expected", 32'(exp8_q.size() != 0), 32'd1);
        if (exp8_q.size() != 0) chk("rdat8", 32'(rdat8), 32'(exp8_q.pop_front()));
      end
      if (rv1) begin
        chk("rv1_expected", 32'(exp1_q.size() != 0), 32'd1);
        if (exp1_q.size() != 0) chk("rdat1", 32'(rdat1), 32'(exp1_q.pop_front()));
      end
      if (wb8.o_wb_cyc && wb8.i_wb_ack && wb8.o_wb_we) begin
        chk("wr_expected", 32'(expwr_q.size() != 0), 32'd1);
        if (expwr_q.size() != 0) begin
          logic [35:0] e;
          e = expwr_q.pop_front();
          chk("wr_dat", wb8.o_wb_dat, e[31:0]);
          chk("wr_sel", 32'(wb8.o_wb_sel), 32'(e[35:32]));
        end
      end
    end
  end

  // give_ack=0 leaves the bus silent; ack_dly=TMO-1 lands ack on the timeout cycle.
  task automatic load8(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] rdt,
                       input bit give_ack, input int ack_dly);
    int n;
    bit exp_err;
    exp_err = !give_ack;
    tick();
    req8 = 1; we8 = 0; adr8 = adr; sel8 = sel;
    tick();
    req8 = 0; adr8 = $urandom; sel8 = 4'($urandom_range(0, 15));
    chk("ld_cyc", 32'(wb8.o_wb_cyc), 32'd1);
    chk("ld_adr", wb8.o_wb_adr, adr & 32'hFFFF_FFFC);
    chk("ld_we", 32'(wb8.o_wb_we), 32'd0);
    chk("ld_sel", 32'(wb8.o_wb_sel), 32'(sel));
    if (give_ack) begin
      for (int i = 0; i < ack_dly; i++) begin
        tick();
        chk("ld_cyc_hold", 32'(wb8.o_wb_cyc), 32'd1);
      end
      wb8.i_wb_rdt = rdt;
      wb8.i_wb_ack = 1;
      for (int i = 0; i < 4; i++) exp8_q.push_back(rdt[8*i +: 8]);
      tick();
      wb8.i_wb_ack = 0;
      wb8.i_wb_rdt = $urandom;
    end else begin
      n = 0;
      while (wb8.o_wb_cyc && n < 40) begin
        n++;
        tick();
      end
      chk("tmo_cyc_len", n, TMO);
      for (int i = 0; i < 4; i++) exp8_q.push_back(8'h00);
    end
    chk("ld_cyc_drop", 32'(wb8.o_wb_cyc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ld_rvalid", 32'(rv8), 32'd1);
      chk("ld_no_done", 32'(done8), 32'd0);
      tick();
    end
    chk("ld_rvalid_end", 32'(rv8), 32'd0);
    chk("ld_done", 32'(done8), 32'd1);
    chk("ld_err", 32'(err8), 32'(exp_err));
    tick();
    chk("ld_done_pulse", 32'(done8), 32'd0);
    chk("ld_idle", 32'(busy8), 32'd0);
    chk("ld_q_empty", exp8_q.size(), 0);
  endtask

  task automatic store8(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                        input bit gap, input bit give_ack, input int ack_dly);
    int n;
    tick();
    req8 = 1; we8 = 1; adr8 = adr; sel8 = sel;
    tick();
    req8 = 0; we8 = 0;
    chk("st_state", 32'(st8), 32'(ST_WCOLLECT));
    chk("st_no_cyc", 32'(wb8.o_wb_cyc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gap) begin
        wvalid8 = 0; wdat8 = 8'($urandom);
        tick();
        chk("st_gap_hold", 32'(st8), 32'(ST_WCOLLECT));
      end
      wvalid8 = 1; wdat8 = dat[8*i +: 8];
      tick();
    end
    wvalid8 = 0; wdat8 = 8'($urandom);
    chk("st_cyc", 32'(wb8.o_wb_cyc), 32'd1);
    chk("st_we", 32'(wb8.o_wb_we), 32'd1);
    chk("st_adr", wb8.o_wb_adr, adr & 32'hFFFF_FFFC);
    chk("st_dat", wb8.o_wb_dat, dat);
    if (give_ack) begin
      for (int i = 0; i < ack_dly; i++) begin
        wvalid8 = 1;
        tick();
        chk("st_cyc_hold", 32'(wb8.o_wb_cyc), 32'd1);
        chk("st_dat_hold", wb8.o_wb_dat, dat);
      end
      wvalid8 = 0;
      expwr_q.push_back({sel, dat});
      wb8.i_wb_ack = 1;
      tick();
      wb8.i_wb_ack = 0;
      chk("st_cyc_drop", 32'(wb8.o_wb_cyc), 32'd0);
    end else begin
      n = 0;
      while (wb8.o_wb_cyc && n < 40) begin
        n++;
        tick();
      end
      chk("st_tmo_len", n, TMO);
    end
    chk("st_done", 32'(done8), 32'd1);
    chk("st_err", 32'(err8), 32'(!give_ack));
    tick();
    chk("st_done_pulse", 32'(done8), 32'd0);
    chk("st_idle", 32'(busy8), 32'd0);
    chk("st_q_empty", expwr_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    wb8.i_wb_ack = 0; wb8.i_wb_rdt = '0;
    wb1.i_wb_ack = 0; wb1.i_wb_rdt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb8.o_wb_cyc), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_adr", wb8.o_wb_adr, 32'd0);
    chk("rst_dat", wb8.o_wb_dat, 32'd0);
    chk("rst_state", 32'(st8), 32'(ST_IDLE));
    chk("rst_outs", {28'd0, rv8, done8, err8, busy1}, 32'd0);
    rst_n = 1;

    // Stray ack/wvalid in IDLE must not start anything.
    tick();
    wb8.i_wb_ack = 1; wvalid8 = 1;
    tick();
    wb8.i_wb_ack = 0; wvalid8 = 0;
    chk("idle_ignore", 32'(busy8), 32'd0);

    load8(32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 1, 3);
    store8(32'h0000_2008, 4'h3, 32'h4433_2211, 1, 1, 2);
    load8(32'h0000_3000, 4'hF, 32'hCAFE_F00D, 0, 0);
    load8(32'h0000_3004, 4'hF, 32'h1234_5678, 1, TMO - 1);
    store8(32'h0000_4000, 4'hF, 32'hA5A5_5A5A, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      rd = $urandom;
      if (k % 2 == 0)
        load8($urandom, 4'($urandom_range(1, 15)), rd, 1, $urandom_range(0, TMO - 2));
      else
        store8($urandom, 4'($urandom_range(1, 15)), rd, 1'($urandom_range(0, 1)), 1,
               $urandom_range(0, TMO - 2));
    end

    // Asynchronous reset while cyc is high.
    tick();
    req8 = 1; we8 = 0; adr8 = 32'h5000;
    tick();
    req8 = 0;
    tick();
    chk("pre_rst_cyc", 32'(wb8.o_wb_cyc), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_cyc", 32'(wb8.o_wb_cyc), 32'd0);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_rvalid", 32'(rv8), 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_done", 32'(done8), 32'd0);
    end
    load8(32'h0000_6000, 4'hF, 32'h0BAD_F00D, 1, 1);

    // W=1: 32 serial beats; requests during RSHIFT are ignored.
    tick();
    req1 = 1; we1 = 0; adr1 = 32'h7000; sel1 = 4'hF;
    tick();
    req1 = 0;
    chk("w1_cyc", 32'(wb1.o_wb_cyc), 32'd1);
    rd = 32'h8000_0001;
    wb1.i_wb_rdt = rd;
    wb1.i_wb_ack = 1;
    for (int i = 0; i < 32; i++) exp1_q.push_back(rd[i]);
    tick();
    wb1.i_wb_ack = 0;
    n = 0;
    while (rv1 && n < 40) begin
      req1 = (n % 5 == 2);
      tick();
      n++;
    end
    req1 = 0;
    chk("w1_beats", n, 32);
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_err", 32'(err1), 32'd0);
    tick();
    chk("w1_idle", 32'(busy1), 32'd0);
    chk("w1_q_empty", exp1_q.size(), 0);

    tick();
    chk("final_q8", exp8_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
